// File: rtl/frame_capture_ctrl.sv
// frame_capture_ctrl
// Arms on a start command and aligns to the next vsync falling edge. It then
// writes each accepted pixel to a linear frame-buffer address through a
// one-entry output register. Each frame's pixel count is checked, and frame
// completion, frame errors and dropped pixels are reported.
module frame_capture_ctrl #(
    parameter int H_ACTIVE = 1280,
    parameter int V_ACTIVE = 720,
    parameter int ADDR_W   = 20
) (
    input  logic              clk_in,
    input  logic              rst_n_in,
    input  logic              start_in,
    input  logic              continuous_in,
    input  logic              stop_in,
    input  logic              pix_valid_in,
    input  logic [15:0]       pix_data_in,
    input  logic              vsync_in,
    input  logic              wr_ready_in,
    output logic              wr_valid_out,
    output logic [ADDR_W-1:0] wr_addr_out,
    output logic [15:0]       wr_data_out,
    output logic              busy_out,
    output logic              frame_done_out,
    output logic              frame_err_out,
    output logic              overflow_out,
    output logic [15:0]       frame_count_out
);

    localparam int FRAME_PIX = H_ACTIVE * V_ACTIVE;
    // One extra bit so the counter can sit at FRAME_PIX+1 and flag a long frame
    localparam int CNT_W = ADDR_W + 1;
    localparam logic [CNT_W-1:0] FRAME_CNT = CNT_W'(FRAME_PIX);
    localparam logic [CNT_W-1:0] SAT_CNT   = CNT_W'(FRAME_PIX + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ARMED,
        ST_CAPTURE
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic               r_vsync_prev;
    logic               r_cont;
    logic               r_drop;
    logic [CNT_W-1:0]   r_pix_cnt;
    logic               r_wr_valid;
    logic [ADDR_W-1:0]  r_wr_addr;
    logic [15:0]        r_wr_data;
    logic               r_frame_done;
    logic               r_frame_err;
    logic               r_overflow;
    logic [15:0]        r_frame_count;

    logic               w_boundary;
    logic               w_capturing;
    logic               w_accept_start;
    logic               w_cap_pix;
    logic               w_offer;
    logic               w_load;
    logic               w_drop;
    logic               w_consume;
    logic               w_frame_end;
    logic [CNT_W-1:0]   w_cnt_inc;

    // The boundary is a vsync falling edge, seen every cycle regardless of pixel strobes
    assign w_boundary     = r_vsync_prev & ~vsync_in;
    assign w_capturing    = (r_state == ST_CAPTURE);
    assign w_accept_start = (r_state == ST_IDLE) & start_in;
    assign w_cap_pix      = w_capturing & pix_valid_in;
    // Pixels past the end of the frame are counted but never written
    assign w_offer        = w_cap_pix & (r_pix_cnt < FRAME_CNT);
    assign w_consume      = r_wr_valid & wr_ready_in;
    assign w_load         = w_offer & (~r_wr_valid | wr_ready_in);
    assign w_drop         = w_offer & ~w_load;
    assign w_frame_end    = w_capturing & w_boundary;
    // The count includes a pixel that arrives with the boundary, because that pixel belongs to the ending frame
    assign w_cnt_inc      = (w_cap_pix && r_pix_cnt != SAT_CNT) ? r_pix_cnt + 1'b1 : r_pix_cnt;

    // FSM state register
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        // NOTE: state is updated with non-blocking assignments so every process samples the pre-edge values
        if (!rst_n_in) r_state <= ST_IDLE;
        else           r_state <= w_state_nxt;
    end

    // Next-state logic; stop in ARMED beats a coincident boundary, and stop in CAPTURE ends continuous mode
    always_comb begin
        // NOTE: default first so every path assigns the next state and no latch is inferred
        w_state_nxt = r_state;
        unique case (r_state)
            ST_IDLE: begin
                if (start_in) w_state_nxt = ST_ARMED;
            end
            ST_ARMED: begin
                if (stop_in)         w_state_nxt = ST_IDLE;
                else if (w_boundary) w_state_nxt = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                if (w_boundary && !(r_cont && !stop_in)) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Mode, pixel counting, frame status and counters
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_vsync_prev  <= 1'b0;
            r_cont        <= 1'b0;
            r_drop        <= 1'b0;
            r_pix_cnt     <= '0;
            r_frame_done  <= 1'b0;
            r_frame_err   <= 1'b0;
            r_overflow    <= 1'b0;
            r_frame_count <= '0;
        end else begin
            r_vsync_prev <= vsync_in;
            r_frame_done <= w_frame_end;
            r_frame_err  <= w_frame_end & ((w_cnt_inc != FRAME_CNT) | r_drop | w_drop);

            if (w_accept_start) begin
                r_cont        <= continuous_in;
                r_overflow    <= 1'b0;
                r_frame_count <= '0;
            end else begin
                if (w_capturing && stop_in) r_cont <= 1'b0;
                if (w_drop)                 r_overflow <= 1'b1;
                if (w_frame_end)            r_frame_count <= r_frame_count + 16'd1;
            end

            // The boundary that ends one frame also starts the next one from address zero
            if (!w_capturing || w_frame_end) begin
                r_pix_cnt <= '0;
                r_drop    <= 1'b0;
            end else begin
                r_pix_cnt <= w_cnt_inc;
                if (w_drop) r_drop <= 1'b1;
            end
        end
    end

    // One-entry output register; it holds its entry until the write is accepted
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_wr_valid <= 1'b0;
            r_wr_addr  <= '0;
            r_wr_data  <= '0;
        end else if (w_load) begin
            r_wr_valid <= 1'b1;
            r_wr_addr  <= r_pix_cnt[ADDR_W-1:0];
            r_wr_data  <= pix_data_in;
        end else if (w_consume) begin
            r_wr_valid <= 1'b0;
        end
    end

    assign wr_valid_out    = r_wr_valid;
    assign wr_addr_out     = r_wr_addr;
    assign wr_data_out     = r_wr_data;
    assign busy_out        = (r_state != ST_IDLE) | r_wr_valid;
    assign frame_done_out  = r_frame_done;
    assign frame_err_out   = r_frame_err;
    assign overflow_out    = r_overflow;
    assign frame_count_out = r_frame_count;

endmodule

// File: tb/tb_frame_capture_ctrl.sv
// Directed testbench for frame_capture_ctrl using 4x2 frames (8 pixels).
module tb_frame_capture_ctrl;

    localparam int ADDR_W = 20;

    logic              clk_in = 1'b0;
    logic              rst_n_in;
    logic              start_in;
    logic              continuous_in;
    logic              stop_in;
    logic              pix_valid_in;
    logic [15:0]       pix_data_in;
    logic              vsync_in;
    logic              wr_ready_in;
    logic              wr_valid_out;
    logic [ADDR_W-1:0] wr_addr_out;
    logic [15:0]       wr_data_out;
    logic              busy_out;
    logic              frame_done_out;
    logic              frame_err_out;
    logic              overflow_out;
    logic [15:0]       frame_count_out;

    int tests_run = 0;
    int tests_failed = 0;

    frame_capture_ctrl #(.H_ACTIVE(4), .V_ACTIVE(2), .ADDR_W(ADDR_W)) dut (
        .clk_in          (clk_in),
        .rst_n_in        (rst_n_in),
        .start_in        (start_in),
        .continuous_in   (continuous_in),
        .stop_in         (stop_in),
        .pix_valid_in    (pix_valid_in),
        .pix_data_in     (pix_data_in),
        .vsync_in        (vsync_in),
        .wr_ready_in     (wr_ready_in),
        .wr_valid_out    (wr_valid_out),
        .wr_addr_out     (wr_addr_out),
        .wr_data_out     (wr_data_out),
        .busy_out        (busy_out),
        .frame_done_out  (frame_done_out),
        .frame_err_out   (frame_err_out),
        .overflow_out    (overflow_out),
        .frame_count_out (frame_count_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and settle just after the edge
    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    // One pixel cycle, followed by a check of the write port in the next cycle
    task automatic send_pix(input string tag, input logic [15:0] d, input logic exp_wr,
                            input int exp_addr, input logic [15:0] exp_data);
        pix_valid_in = 1'b1;
        pix_data_in  = d;
        tick();
        pix_valid_in = 1'b0;
        check({tag, ".valid"}, {31'd0, wr_valid_out}, {31'd0, exp_wr});
        if (exp_wr) begin
            check({tag, ".addr"}, 32'(wr_addr_out), 32'(exp_addr));
            check({tag, ".data"}, {16'd0, wr_data_out}, {16'd0, exp_data});
        end
    endtask

    // One cycle of vsync low after high gives a falling edge
    task automatic boundary();
        vsync_in = 1'b0;
        tick();
        vsync_in = 1'b1;
    endtask

    task automatic check_done(input string tag, input logic done, input logic err, input int cnt);
        check({tag, ".done"},  {31'd0, frame_done_out}, {31'd0, done});
        check({tag, ".err"},   {31'd0, frame_err_out},  {31'd0, err});
        check({tag, ".count"}, {16'd0, frame_count_out}, 32'(cnt));
    endtask

    task automatic start_cmd(input logic cont);
        start_in      = 1'b1;
        continuous_in = cont;
        tick();
        start_in      = 1'b0;
        continuous_in = 1'b0;
    endtask

    // Eight in-frame pixels with free writes to addresses 0..7
    task automatic full_frame(input string tag, input logic [15:0] base);
        for (int i = 0; i < 8; i++)
            send_pix($sformatf("%s.px%0d", tag, i), base + 16'(i), 1'b1, i, base + 16'(i));
    endtask

    initial begin
        rst_n_in      = 1'b0;
        start_in      = 1'b0;
        continuous_in = 1'b0;
        stop_in       = 1'b0;
        pix_valid_in  = 1'b0;
        pix_data_in   = 16'd0;
        vsync_in      = 1'b1;
        wr_ready_in   = 1'b1;
        #2;
        check("rst.valid", {31'd0, wr_valid_out}, 32'd0);
        check("rst.busy",  {31'd0, busy_out}, 32'd0);
        check("rst.done",  {31'd0, frame_done_out}, 32'd0);
        check("rst.ovf",   {31'd0, overflow_out}, 32'd0);
        check("rst.count", {16'd0, frame_count_out}, 32'd0);
        tick();
        rst_n_in = 1'b1;
        tick();
        tick();

        // Single shot; a pixel before the first boundary is ignored
        start_cmd(1'b0);
        check("ss.busy_armed", {31'd0, busy_out}, 32'd1);
        send_pix("ss.pre", 16'h1111, 1'b0, 0, 16'h0);
        boundary();
        check_done("ss.arm_bnd", 1'b0, 1'b0, 0);
        full_frame("ss", 16'hA000);
        boundary();
        check_done("ss.end", 1'b1, 1'b0, 1);
        check("ss.busy_idle", {31'd0, busy_out}, 32'd0);
        tick();
        check("ss.done_pulse", {31'd0, frame_done_out}, 32'd0);

        // Continuous, three frames, stop during frame 3
        start_cmd(1'b1);
        check("ct.count_clr", {16'd0, frame_count_out}, 32'd0);
        boundary();
        full_frame("ct.f1", 16'hB000);
        boundary();
        check_done("ct.f1end", 1'b1, 1'b0, 1);
        full_frame("ct.f2", 16'hB100);
        boundary();
        check_done("ct.f2end", 1'b1, 1'b0, 2);
        for (int i = 0; i < 3; i++)
            send_pix($sformatf("ct.f3.px%0d", i), 16'hB200 + 16'(i), 1'b1, i, 16'hB200 + 16'(i));
        stop_in = 1'b1;
        tick();
        stop_in = 1'b0;
        check("ct.busy_stop", {31'd0, busy_out}, 32'd1);
        for (int i = 3; i < 8; i++)
            send_pix($sformatf("ct.f3.px%0d", i), 16'hB200 + 16'(i), 1'b1, i, 16'hB200 + 16'(i));
        boundary();
        check_done("ct.f3end", 1'b1, 1'b0, 3);
        check("ct.busy_idle", {31'd0, busy_out}, 32'd0);
        send_pix("ct.idle_px", 16'hB300, 1'b0, 0, 16'h0);
        boundary();
        check_done("ct.idle_bnd", 1'b0, 1'b0, 3);

        // Short then long frame; the long frame ends with stop and boundary together
        start_cmd(1'b1);
        boundary();
        for (int i = 0; i < 7; i++)
            send_pix($sformatf("sl.s%0d", i), 16'hC000 + 16'(i), 1'b1, i, 16'hC000 + 16'(i));
        boundary();
        check_done("sl.short", 1'b1, 1'b1, 1);
        full_frame("sl.l", 16'hC100);
        send_pix("sl.l8", 16'hC108, 1'b0, 0, 16'h0);
        stop_in = 1'b1;
        boundary();
        stop_in = 1'b0;
        check_done("sl.long", 1'b1, 1'b1, 2);
        check("sl.busy_idle", {31'd0, busy_out}, 32'd0);

        // Backpressure: three stalled cycles, the held pixel stays stable and two are dropped
        start_cmd(1'b0);
        boundary();
        wr_ready_in = 1'b0;
        send_pix("bp.p0", 16'hD000, 1'b1, 0, 16'hD000);
        send_pix("bp.p1", 16'hD001, 1'b1, 0, 16'hD000);
        check("bp.ovf", {31'd0, overflow_out}, 32'd1);
        send_pix("bp.p2", 16'hD002, 1'b1, 0, 16'hD000);
        wr_ready_in = 1'b1;
        for (int i = 3; i < 8; i++)
            send_pix($sformatf("bp.p%0d", i), 16'hD000 + 16'(i), 1'b1, i, 16'hD000 + 16'(i));
        boundary();
        check_done("bp.end", 1'b1, 1'b1, 1);
        check("bp.ovf_sticky", {31'd0, overflow_out}, 32'd1);
        start_cmd(1'b0);
        check("bp.ovf_clr", {31'd0, overflow_out}, 32'd0);

        // Stop while armed, alone and together with a boundary
        stop_in = 1'b1;
        tick();
        stop_in = 1'b0;
        check("arm.stop_idle", {31'd0, busy_out}, 32'd0);
        check("arm.count", {16'd0, frame_count_out}, 32'd0);
        start_cmd(1'b0);
        stop_in = 1'b1;
        boundary();
        stop_in = 1'b0;
        check("arm.stopbnd_idle", {31'd0, busy_out}, 32'd0);
        send_pix("arm.nopx", 16'hE000, 1'b0, 0, 16'h0);

        // Asynchronous reset in the middle of a continuous capture
        start_cmd(1'b1);
        boundary();
        full_frame("ar.f1", 16'hF000);
        boundary();
        check_done("ar.f1end", 1'b1, 1'b0, 1);
        for (int i = 0; i < 3; i++)
            send_pix($sformatf("ar.px%0d", i), 16'hF100 + 16'(i), 1'b1, i, 16'hF100 + 16'(i));
        #2;
        rst_n_in = 1'b0;
        #1;
        check("ar.valid", {31'd0, wr_valid_out}, 32'd0);
        check("ar.addr",  32'(wr_addr_out), 32'd0);
        check("ar.data",  {16'd0, wr_data_out}, 32'd0);
        check("ar.busy",  {31'd0, busy_out}, 32'd0);
        check("ar.count", {16'd0, frame_count_out}, 32'd0);
        check("ar.done",  {31'd0, frame_done_out}, 32'd0);
        tick();
        rst_n_in = 1'b1;
        tick();
        boundary();
        check_done("ar.post_bnd", 1'b0, 1'b0, 0);
        check("ar.post_busy", {31'd0, busy_out}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/frame_capture_ctrl.md
# frame_capture_ctrl

Sequences frame capture from the pixel stream produced by the camera coordinate stage and drives a frame-buffer write port. Arms on a start command, aligns to the next frame boundary, and writes each accepted pixel to a linear address. Supports single-shot and continuous modes, checks that each frame has the expected pixel count, and reports completion, errors and output-side overflow.

## Interface
- H_ACTIVE, 1280, active pixels per line.
- V_ACTIVE, 720, active lines per frame.
- ADDR_W, 20, write address width; H_ACTIVE*V_ACTIVE <= 2^ADDR_W.
- clk_in  input  1  single clock for all logic.
- rst_n_in  input  1  reset; asynchronous assert, active-low.
- start_in  input  1  single-cycle capture command.
- continuous_in  input  1  mode, sampled with start_in: 1 = continuous, 0 = single frame.
- stop_in  input  1  single-cycle stop command.
- pix_valid_in  input  1  pixel strobe from the coordinate stage.
- pix_data_in  input  16  pixel data.
- vsync_in  input  1  raw vsync; high = active frame.
- wr_ready_in  input  1  frame-buffer write accept.
- wr_valid_out  output  1  write request.
- wr_addr_out  output  ADDR_W  linear pixel address.
- wr_data_out  output  16  write data.
- busy_out  output  1  high when not IDLE or a write is pending.
- frame_done_out  output  1  one-cycle pulse at the end of a captured frame.
- frame_err_out  output  1  one-cycle pulse, coincident with frame_done_out, when the frame was bad.
- overflow_out  output  1  sticky flag for a dropped pixel; cleared by an accepted start_in.
- frame_count_out  output  16  count of completed frames; wraps at 16 bits; cleared by an accepted start_in.

## Operation
- Boundary: vsync_in falling edge, i.e. vsync_prev==1 && vsync_in==0. It is evaluated every cycle, independent of pix_valid_in. vsync_prev resets to 0.
- States: IDLE, ARMED, CAPTURE.
- IDLE: start_in goes to ARMED and latches continuous_in into cont_q. start_in is ignored in any other state.
- ARMED: waits for a boundary, then goes to CAPTURE with pix_cnt=0. Pixels are ignored. stop_in returns to IDLE.
- CAPTURE, on pix_valid_in:
  - If pix_cnt < H_ACTIVE*V_ACTIVE, the pixel is offered to the output register with addr=pix_cnt.
  - pix_cnt increments, saturating at H_ACTIVE*V_ACTIVE+1.
- CAPTURE, on boundary:
  - Pulse frame_done_out and increment frame_count_out.
  - frame_err_out = (pix_cnt != H_ACTIVE*V_ACTIVE) || drop_q. Then clear drop_q and set pix_cnt=0.
  - If cont_q, stay in CAPTURE; the boundary also starts the next frame. Otherwise go to IDLE.
- stop_in in CAPTURE clears cont_q; the current frame completes normally. stop_in in IDLE has no effect.
- A pixel coincident with a boundary belongs to the ending frame.
- Output register holds one entry:
  - A pixel is loaded when the register is empty or is being consumed that cycle (wr_valid_out && wr_ready_in).
  - Otherwise the pixel is dropped: set overflow_out and drop_q; pix_cnt still increments.
- wr_valid_out stays high with stable addr and data until wr_ready_in.
- A pending write drains after a transition to IDLE. busy_out stays high until it drains.

## Timing
- Reset values:
  - State IDLE; cont_q, drop_q and pix_cnt cleared.
  - wr_valid_out, wr_addr_out, wr_data_out, busy_out, frame_done_out, frame_err_out, overflow_out and frame_count_out all 0.
- start_in at cycle N: state is ARMED and busy_out=1 at N+1.
- Boundary detected at cycle N: CAPTURE is active from N+1, so a pixel at N+1 gets addr 0.
- Pixel at cycle N with a free register: wr_valid_out=1 with its data and address at N+1. Latency is 1 cycle.
- Boundary at cycle N in CAPTURE: frame_done_out, frame_err_out and the updated frame_count_out appear at N+1.
- Simultaneous stop_in and boundary in CAPTURE: the frame completes and the next state is IDLE.
- Simultaneous stop_in and boundary in ARMED: go to IDLE; no capture starts.
- Simultaneous start_in and stop_in in IDLE: start wins.
- Reset asserted mid-frame: all state clears immediately and no done pulse is generated.

## Test plan
Tests use H_ACTIVE=4 and V_ACTIVE=2, with wr_ready_in=1 unless stated.
- Single shot: start_in, boundary, 8 pixels D0..D7, boundary -> writes to addr 0..7 with data D0..D7; one frame_done_out with frame_err_out=0; frame_count_out=1; state IDLE.
- Continuous over 3 frames of 8 pixels, stop_in during frame 3 -> addresses restart at 0 after each boundary; 3 done pulses; frame_count_out=3; IDLE after frame 3.
- Short/long frames: 7 pixels, then 9 pixels -> both frames pulse frame_err_out; in the 9-pixel frame the 9th pixel is not written.
- Backpressure: wr_ready_in=0 for 3 cycles with pixels arriving every cycle -> first pixel held stable, next 2 dropped; overflow_out=1; frame_err_out at frame end; next start_in clears overflow_out.
- Arming: pixels before the first boundary and stop_in in ARMED -> no writes; IDLE next cycle; frame_count_out unchanged.
- Async reset mid-capture -> all outputs 0 without a clock edge; no frame_done_out.
